// File: rtl/bounce_gen.sv
// ---------------------------------------------------------------------------
// bounce_gen -- contact-bounce emulator
//
// Takes a clean logic level and drives a registered output that behaves like
// a mechanical switch contact. Each accepted edge of the input starts two
// phases:
//   1. BOUNCE: a window of BOUNCE_CYCLES clocks. In each cycle the output
//      toggles whenever the LFSR bit 0 is set.
//   2. SETTLE: SETTLE_CYCLES clocks in which the output is held at the new
//      level.
// A one-cycle done pulse marks the end of each emulated edge. When en_i is
// low the level passes through cleanly, with two clocks of latency from
// in_i to out_o.
//
// The LFSR advances only during BOUNCE cycles. The same stimulus after reset
// therefore always produces the same out_o waveform.
//
// Ports:
//   clk          input   system clock, rising edge
//   rst          input   asynchronous active-high reset
//   in_i         input   clean level to emulate
//   en_i         input   1 = bounce emulation, 0 = clean pass-through
//                        (sampled only while idle)
//   out_o        output  emulated switch output (registered)
//   busy_o       output  high while an edge is being emulated
//   done_o       output  one-cycle pulse when an emulated edge completes
//   bounce_cnt_o output  toggles in the most recent bounce window (sat. 255)
// ---------------------------------------------------------------------------
module bounce_gen #(
  parameter int          BOUNCE_CYCLES = 64,     // 1..256
  parameter int          SETTLE_CYCLES = 300,    // 1..65536
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_i,
  input  logic       en_i,
  output logic       out_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] bounce_cnt_o
);

  // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
  localparam logic [7:0]  SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [7:0]  WIN_LOAD = 8'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] SET_LOAD = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1. It shifts left and feeds back
  // into bit 0.
  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

  // Saturating 8-bit increment for the toggle counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] cur);
    return (cur == 8'hFF) ? 8'hFF : (cur + 8'h01);
  endfunction

  state_t      state_q;
  logic        in_reg_q;
  logic        level_q;
  logic        target_q;
  logic [7:0]  win_cnt_q;
  logic [15:0] set_cnt_q;
  logic [7:0]  lfsr_q;
  logic        out_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  bounce_cnt_q;

  logic [7:0]  lfsr_d;
  logic [7:0]  bounce_cnt_d;
  logic        edge_seen_d;

  // Next-value helpers for the FSM: LFSR step, saturated count, edge detect.
  always_comb begin
    lfsr_d       = lfsr_step(lfsr_q);
    bounce_cnt_d = sat_inc8(bounce_cnt_q);
    edge_seen_d  = (in_reg_q != level_q);
  end

  // Main FSM. All outputs come straight from registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_reg_q     <= 1'b0;
      level_q      <= 1'b0;
      target_q     <= 1'b0;
      win_cnt_q    <= 8'h00;
      set_cnt_q    <= 16'h0000;
      lfsr_q       <= SEED_EFF;
      out_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bounce_cnt_q <= 8'h00;
    end else begin
      in_reg_q <= in_i;
      done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (edge_seen_d) begin
            if (en_i) begin
              target_q     <= in_reg_q;
              win_cnt_q    <= WIN_LOAD;
              bounce_cnt_q <= 8'h00;
              busy_q       <= 1'b1;
              state_q      <= ST_BOUNCE;
            end else begin
              // Clean pass-through; no done pulse and bounce_cnt is kept.
              level_q <= in_reg_q;
              out_q   <= in_reg_q;
            end
          end else begin
            out_q <= level_q;
          end
        end

        ST_BOUNCE: begin
          lfsr_q <= lfsr_d;
          if (lfsr_q[0]) begin
            bounce_cnt_q <= bounce_cnt_d;
          end else begin
            bounce_cnt_q <= bounce_cnt_q;
          end
          if (win_cnt_q == 8'h00) begin
            // The last window cycle always forces the target level, so the
            // parity of the toggle count never leaves out at the wrong level.
            out_q     <= target_q;
            set_cnt_q <= SET_LOAD;
            state_q   <= ST_SETTLE;
          end else begin
            if (lfsr_q[0]) begin
              out_q <= ~out_q;
            end else begin
              out_q <= out_q;
            end
            win_cnt_q <= win_cnt_q - 8'h01;
          end
        end

        ST_SETTLE: begin
          out_q <= target_q;
          if (set_cnt_q == 16'h0000) begin
            level_q <= target_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            set_cnt_q <= set_cnt_q - 16'h0001;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          out_q   <= level_q;
        end
      endcase
    end
  end

  assign out_o        = out_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign bounce_cnt_o = bounce_cnt_q;

endmodule

// File: tb/tb_bounce_gen.sv
// ---------------------------------------------------------------------------
// tb_bounce_gen -- self-checking bench for bounce_gen
//
// Expected {out,busy,done} values are pushed to a queue for each cycle when
// stimulus is applied. The values are then popped and compared at each
// falling edge. The expected bounce waveform comes from a reference LFSR
// kept in the bench.
// ---------------------------------------------------------------------------
module tb_bounce_gen;

  localparam int         B    = 16;
  localparam int         S    = 32;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_i;
  logic       en_i;
  logic       out_o;
  logic       busy_o;
  logic       done_o;
  logic [7:0] bounce_cnt_o;

  bounce_gen #(
    .BOUNCE_CYCLES(B),
    .SETTLE_CYCLES(S),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_i(in_i),
    .en_i(en_i),
    .out_o(out_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .bounce_cnt_o(bounce_cnt_o)
  );

  always #5 clk = ~clk;

  logic [2:0] exp_q[$];
  int         pass_cnt  = 0;
  int         total_cnt = 0;
  logic [7:0] m_lfsr;
  logic [7:0] m_cnt;
  logic       m_level;

  function automatic logic [7:0] model_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic void push_idle(input logic o);
    exp_q.push_back({o, 1'b0, 1'b0});
  endfunction

  // Pushes one emulated edge: the BOUNCE entry cycle, B window cycles and
  // S settle cycles. The last settle cycle carries the done pulse.
  function automatic void push_event(input logic old_lv, input logic tgt);
    logic       o;
    logic [7:0] cnt;
    o   = old_lv;
    cnt = 8'h00;
    exp_q.push_back({o, 1'b1, 1'b0});
    for (int j = 1; j <= B; j++) begin
      if (m_lfsr[0]) begin
        o = ~o;
        if (cnt != 8'hFF) cnt = cnt + 8'h01;
      end
      m_lfsr = model_step(m_lfsr);
      if (j == B) o = tgt;
      exp_q.push_back({o, 1'b1, 1'b0});
    end
    for (int m = 1; m <= S; m++) begin
      exp_q.push_back({tgt, (m < S), (m == S)});
    end
    m_cnt = cnt;
  endfunction

  task automatic drain(input string name, input int n, input int glitch_at,
                       input int en_off_at, input int en_on_at,
                       output int busy_seen);
    logic [2:0] e;
    logic [2:0] o;
    busy_seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      o = {out_o, busy_o, done_o};
      total_cnt++;
      if (o !== e)
        $display("FAIL %s cycle %0d: out/busy/done=%b expected %b", name, i, o, e);
      else
        pass_cnt++;
      if (busy_o === 1'b1) busy_seen++;
      if (i == glitch_at) in_i = ~in_i;
      if (i == en_off_at) en_i = 1'b0;
      if (i == en_on_at)  en_i = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    in_i = 1'b0;
    en_i = 1'b0;
    m_lfsr  = SEED;
    m_cnt   = 8'h00;
    m_level = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({out_o, busy_o, done_o, bounce_cnt_o} !== 11'd0)
      $display("FAIL reset_values: out/busy/done/cnt=%b %b %b %h expected 0 0 0 00",
               out_o, busy_o, done_o, bounce_cnt_o);
    else
      pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_bypass(input logic new_lv);
    int bs;
    en_i = 1'b0;
    in_i = new_lv;
    push_idle(m_level);
    push_idle(new_lv);
    push_idle(new_lv);
    m_level = new_lv;
    drain("bypass", 3, -1, -1, -1, bs);
    total_cnt++;
    if (bs != 0) $display("FAIL bypass_busy: busy cycles %0d expected 0", bs);
    else pass_cnt++;
    total_cnt++;
    if (bounce_cnt_o !== m_cnt)
      $display("FAIL bypass_cnt_kept: bounce_cnt %h expected %h", bounce_cnt_o, m_cnt);
    else
      pass_cnt++;
  endtask

  task automatic test_async_reset;
    @(posedge clk);
    #2;
    rst  = 1'b1;
    in_i = 1'b0;
    #1;
    total_cnt++;
    if ({out_o, busy_o, done_o, bounce_cnt_o} !== 11'd0)
      $display("FAIL async_reset: out/busy/done/cnt=%b %b %b %h expected 0 0 0 00",
               out_o, busy_o, done_o, bounce_cnt_o);
    else
      pass_cnt++;
    @(negedge clk);
    rst     = 1'b0;
    m_lfsr  = SEED;
    m_cnt   = 8'h00;
    m_level = 1'b0;
  endtask

  task automatic test_emulated;
    int bs;
    en_i = 1'b1;
    in_i = 1'b1;
    push_idle(1'b0);
    push_event(1'b0, 1'b1);
    push_idle(1'b1);
    m_level = 1'b1;
    drain("emulated", exp_q.size(), -1, -1, -1, bs);
    total_cnt++;
    if (bs != B + S) $display("FAIL emulated_busy_len: busy cycles %0d expected %0d", bs, B + S);
    else pass_cnt++;
    total_cnt++;
    if (bounce_cnt_o !== m_cnt || m_cnt == 8'h00 || m_cnt > 8'(B))
      $display("FAIL emulated_bounce_cnt: bounce_cnt %h expected %h (nonzero, <= %0d)",
               bounce_cnt_o, m_cnt, B);
    else
      pass_cnt++;
  endtask

  task automatic test_glitch;
    int bs;
    en_i = 1'b1;
    in_i = 1'b1;
    push_idle(1'b0);
    push_event(1'b0, 1'b1);
    push_event(1'b1, 1'b0);
    push_idle(1'b0);
    m_level = 1'b0;
    // in_i drops back to 0 in the middle of BOUNCE, and en_i is toggled
    // mid-event; neither may disturb the running event.
    drain("glitch", exp_q.size(), 4, 6, 20, bs);
    total_cnt++;
    if (bs != 2 * (B + S)) $display("FAIL glitch_busy_len: busy cycles %0d expected %0d", bs, 2 * (B + S));
    else pass_cnt++;
    total_cnt++;
    if (bounce_cnt_o !== m_cnt)
      $display("FAIL glitch_bounce_cnt: bounce_cnt %h expected %h", bounce_cnt_o, m_cnt);
    else
      pass_cnt++;
  endtask

  task automatic test_reset_mid_bounce;
    int bs;
    en_i = 1'b1;
    in_i = 1'b1;
    push_idle(1'b0);
    push_event(1'b0, 1'b1);
    drain("mid_bounce_pre", 8, -1, -1, -1, bs);
    #1;
    rst  = 1'b1;
    in_i = 1'b0;
    #1;
    total_cnt++;
    if ({out_o, busy_o, done_o, bounce_cnt_o} !== 11'd0)
      $display("FAIL mid_bounce_reset: out/busy/done/cnt=%b %b %b %h expected 0 0 0 00",
               out_o, busy_o, done_o, bounce_cnt_o);
    else
      pass_cnt++;
    repeat (2) begin
      @(negedge clk);
      total_cnt++;
      if (done_o !== 1'b0 || busy_o !== 1'b0)
        $display("FAIL mid_bounce_no_done: busy/done=%b %b expected 0 0", busy_o, done_o);
      else
        pass_cnt++;
    end
    exp_q.delete();
    m_lfsr  = SEED;
    m_cnt   = 8'h00;
    m_level = 1'b0;
    rst = 1'b0;
    // Same stimulus as test_emulated after reseed: identical waveform expected.
    test_emulated();
  endtask

  initial begin
    test_reset();
    test_bypass(1'b1);
    test_async_reset();
    test_emulated();
    test_bypass(1'b0);
    test_glitch();
    test_reset_mid_bounce();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
